uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8O1 (odd parity) when UART_RX_PARITY_EN is defined.
// Samples each bit at its centre using a baud counter derived from CLK_FREQUENCY/BAUD_RATE.
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       data_strobe,
  output logic       rx_error
);

  localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_CLOCKS = BAUD_CLOCKS / 2;
  localparam int CNT_W       = (BAUD_CLOCKS > 1) ? $clog2(BAUD_CLOCKS) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CLOCKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF_CLOCKS > 0) ? HALF_CLOCKS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PAR,
`endif
    STOP
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_sdin;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [CNT_W-1:0] w_baud_cnt_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic [7:0]       r_dout;
  logic [7:0]       w_dout_next;
  logic             r_rx_error;
  logic             w_rx_error_next;
  logic             r_strobe;
  logic             w_strobe_next;
`ifdef UART_RX_PARITY_EN
  logic             r_par_err;
  logic             w_par_err_next;
`endif

  logic             w_baud_done;
  logic             w_half_done;

  // Both flops reset high so a reset never looks like a falling start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking here so r_sync2 takes the old r_sync1, giving two real flop stages.
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sdin      = r_sync2;
  assign w_baud_done = (r_baud_cnt == BAUD_LAST);
  assign w_half_done = (r_baud_cnt == HALF_LAST);

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    w_state_next    = r_state;
    w_baud_cnt_next = r_baud_cnt + CNT_W'(1);
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_dout_next     = r_dout;
    w_rx_error_next = r_rx_error;
    w_strobe_next   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_err_next  = r_par_err;
`endif

    case (r_state)
      IDLE: begin
        w_baud_cnt_next = '0;
        if (!w_sdin) begin
          w_state_next = START;
        end
      end

      START: begin
        if (w_half_done) begin
          w_baud_cnt_next = '0;
          if (w_sdin) begin
            w_state_next = IDLE;
          end else begin
            w_state_next   = DATA;
            w_bit_idx_next = 3'd0;
          end
        end
      end

      DATA: begin
        if (w_baud_done) begin
          w_baud_cnt_next = '0;
          w_shift_next    = {w_sdin, r_shift[7:1]};
          w_bit_idx_next  = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = PAR;
`else
            w_state_next = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PAR: begin
        if (w_baud_done) begin
          w_baud_cnt_next = '0;
          // Odd parity: an even count of ones over data plus parity is an error.
          w_par_err_next  = ~^{r_shift, w_sdin};
          w_state_next    = STOP;
        end
      end
`endif

      STOP: begin
        if (w_baud_done) begin
          w_baud_cnt_next = '0;
          w_dout_next     = r_shift;
`ifdef UART_RX_PARITY_EN
          w_rx_error_next = ~w_sdin | r_par_err;
`else
          w_rx_error_next = ~w_sdin;
`endif
          w_strobe_next   = 1'b1;
          // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
          w_state_next    = IDLE;
        end
      end

      default: begin
        w_state_next    = IDLE;
        w_baud_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_dout     <= 8'h00;
      r_rx_error <= 1'b0;
      r_strobe   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_dout     <= w_dout_next;
      r_rx_error <= w_rx_error_next;
      r_strobe   <= w_strobe_next;
`ifdef UART_RX_PARITY_EN
      r_par_err  <= w_par_err_next;
`endif
    end
  end

  assign dout        = r_dout;
  assign rx_error    = r_rx_error;
  assign data_strobe = r_strobe;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are modelled as bit lists and expected results
// (data, error flag, strobe time) are derived from the frame contents with plain arithmetic.
`timescale 1ns/1ps
module tb_uart_rx;

  // 32 clocks per bit keeps every scenario short while preserving the bit/half-bit ratios.
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 3_125_000;
  localparam int B        = CLK_FREQ / BAUD;
  localparam int H        = B / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN   = 1'b1;
  localparam int NB       = 10;
`else
  localparam bit PAR_EN   = 1'b0;
  localparam int NB       = 9;
`endif
  localparam int LAT      = H + NB * B;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       din   = 1'b1;
  logic [7:0] dout;
  logic       busy;
  logic       data_strobe;
  logic       rx_error;

  uart_rx #(
    .CLK_FREQUENCY(CLK_FREQ),
    .BAUD_RATE    (BAUD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .dout       (dout),
    .busy       (busy),
    .data_strobe(data_strobe),
    .rx_error   (rx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         t0;
  } frame_t;

  frame_t     exp_q[$];
  frame_t     obs_q[$];
  int         cycle     = 0;
  int         n_checks  = 0;
  int         n_pass    = 0;
  int         busy_rise = -1;
  logic       busy_q    = 1'b0;
  logic [7:0] model_dout = 8'h00;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (data_strobe) obs_q.push_back('{dout, rx_error, cycle});
    if (busy && !busy_q) busy_rise = cycle;
    busy_q = busy;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1);
  end

  // Parity bit value that makes data plus parity contain an odd number of ones.
  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  function automatic logic exp_err(input logic [7:0] d, input logic p, input logic s);
    int ones;
    ones = $countones(d) + ((PAR_EN && p) ? 1 : 0);
    return !s || (PAR_EN && (ones % 2 == 0));
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din = 1'b1;
    end
  endtask

  // Drives one frame; glitch flips each data bit briefly well before its centre,
  // rst_mid pulses reset from data bit 3 until halfway through data bit 7.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input bit glitch, input bit rst_mid);
    logic bits[$];
    int   t0;
    t0 = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (PAR_EN) bits.push_back(p);
    bits.push_back(s);
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < B; c++) begin
        @(negedge clk);
        if (c == 0) begin
          din = bits[k];
          if (k == 0) t0 = cycle;
        end else if (glitch && k >= 1 && k <= 8 && c == 2) begin
          din = ~bits[k];
        end else if (c == 5) begin
          din = bits[k];
        end
        if (rst_mid && k == 4 && c == 0) rst_n = 1'b0;
        if (rst_mid && k == 8 && c == H) rst_n = 1'b1;
      end
    end
    if (rst_mid) begin
      model_dout = 8'h00;
    end else begin
      exp_q.push_back('{d, exp_err(d, p, s), t0});
      model_dout = d;
    end
  endtask

  task automatic test_reset();
    #40;
    n_checks++;
    if (dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++;
    if (data_strobe !== 1'b0) $display("FAIL reset_strobe: got %b expected 0", data_strobe); else n_pass++;
    n_checks++;
    if (rx_error !== 1'b0) $display("FAIL reset_err: got %b expected 0", rx_error); else n_pass++;
    #40;
    rst_n = 1'b1;
    idle(3000);
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL reset_idle_strobes: got %0d expected 0", obs_q.size()); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_timing();
    busy_rise = -1;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2 * B);
    n_checks++;
    if (busy_rise < exp_q[0].t0 || busy_rise > exp_q[0].t0 + 3)
      $display("FAIL timing_busy_rise: got %0d cycles expected 0..3", busy_rise - exp_q[0].t0);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL timing_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].err !== exp_q[i].err)
        $display("FAIL timing_frame%0d: got %h/%b expected %h/%b", i, obs_q[i].data, obs_q[i].err,
                 exp_q[i].data, exp_q[i].err);
      else n_pass++;
      n_checks++;
      if (obs_q[i].t0 - exp_q[i].t0 < LAT - 3 || obs_q[i].t0 - exp_q[i].t0 > LAT + 3)
        $display("FAIL timing_latency%0d: got %0d cycles expected %0d +-3", i,
                 obs_q[i].t0 - exp_q[i].t0, LAT);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_parity();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(B);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2 * B);
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL parity_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].err !== exp_q[i].err)
        $display("FAIL parity_frame%0d: got %h/%b expected %h/%b", i, obs_q[i].data, obs_q[i].err,
                 exp_q[i].data, exp_q[i].err);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_framing();
    send_frame(8'h81, odd_par(8'h81), 1'b0, 1'b0, 1'b0);
    idle(3 * B);
    n_checks++;
    if (rx_error !== 1'b1) $display("FAIL framing_err_hold: got %b expected 1", rx_error); else n_pass++;
    send_frame(8'h7E, odd_par(8'h7E), 1'b1, 1'b0, 1'b0);
    idle(2 * B);
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL framing_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].err !== exp_q[i].err)
        $display("FAIL framing_frame%0d: got %h/%b expected %h/%b", i, obs_q[i].data, obs_q[i].err,
                 exp_q[i].data, exp_q[i].err);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals[3];
    vals = '{8'h00, 8'hFF, 8'h55};
    busy_rise = -1;
    // A low pulse shorter than half a bit is a false start.
    repeat (H / 2) begin
      @(negedge clk);
      din = 1'b0;
    end
    idle(2 * B);
    n_checks++;
    if (busy_rise < 0) $display("FAIL false_start_busy: got no busy pulse expected one"); else n_pass++;
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL false_start_strobes: got %0d expected 0", obs_q.size()); else n_pass++;
    n_checks++;
    if (dout !== model_dout) $display("FAIL false_start_dout: got %h expected %h", dout, model_dout); else n_pass++;
    obs_q.delete();
    for (int i = 0; i < 3; i++) send_frame(vals[i], odd_par(vals[i]), 1'b1, 1'b0, 1'b0);
    idle(2 * B);
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL b2b_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].err !== exp_q[i].err)
        $display("FAIL b2b_frame%0d: got %h/%b expected %h/%b", i, obs_q[i].data, obs_q[i].err,
                 exp_q[i].data, exp_q[i].err);
      else n_pass++;
      n_checks++;
      if (obs_q[i].t0 - exp_q[i].t0 < LAT - 3 || obs_q[i].t0 - exp_q[i].t0 > LAT + 3)
        $display("FAIL b2b_latency%0d: got %0d cycles expected %0d +-3", i,
                 obs_q[i].t0 - exp_q[i].t0, LAT);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h96, odd_par(8'h96), 1'b1, 1'b0, 1'b1);
    idle(2 * B);
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL abort_strobes: got %0d expected 0", obs_q.size()); else n_pass++;
    n_checks++;
    if (dout !== model_dout) $display("FAIL abort_dout: got %h expected %h", dout, model_dout); else n_pass++;
    obs_q.delete();
    send_frame(8'h12, odd_par(8'h12), 1'b1, 1'b0, 1'b0);
    idle(2 * B);
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL abort_next_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].err !== exp_q[i].err)
        $display("FAIL abort_next_frame%0d: got %h/%b expected %h/%b", i, obs_q[i].data, obs_q[i].err,
                 exp_q[i].data, exp_q[i].err);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       p;
    logic       s;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      p = ($urandom_range(0, 3) != 0) ? odd_par(d) : ~odd_par(d);
      s = ($urandom_range(0, 4) != 0);
      send_frame(d, p, s, 1'($urandom_range(0, 1)), 1'b0);
      idle(s ? int'($urandom_range(0, B)) : 2 * B);
    end
    idle(2 * B);
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL random_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].err !== exp_q[i].err)
        $display("FAIL random_frame%0d: got %h/%b expected %h/%b", i, obs_q[i].data, obs_q[i].err,
                 exp_q[i].data, exp_q[i].err);
      else n_pass++;
      n_checks++;
      if (obs_q[i].t0 - exp_q[i].t0 < LAT - 3 || obs_q[i].t0 - exp_q[i].t0 > LAT + 3)
        $display("FAIL random_latency%0d: got %0d cycles expected %0d +-3", i,
                 obs_q[i].t0 - exp_q[i].t0, LAT);
      else n_pass++;
    end
    n_checks++;
    if (dout !== model_dout) $display("FAIL random_dout_hold: got %h expected %h", dout, model_dout); else n_pass++;
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_timing();
    test_parity();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
